// File: rtl/reduce_scheduler.sv
// Round-robin scheduler that hands a single reducer to one requester at a time.
// Each grant carries one BURST_LEN-pair key word, followed by a fixed idle gap.
module reduce_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_SIZE  = 32,
   parameter int BURST_LEN  = 4,
   parameter int GAP_CYCLES = 2,
   parameter int MAX_KEYS   = 64,
   parameter int KW         = $clog2(MAX_KEYS) + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           red_write,
   output logic [DATA_SIZE-1:0]           red_pair,
   output logic                           busy,
   output logic                           full,
   output logic [KW-1:0]                  keys_sent
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(BURST_LEN) + 1;
   localparam int GW = $clog2(GAP_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_FULL} state_e;

   state_e                 state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [IW-1:0]          last_q, last_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [KW-1:0]          keys_q, keys_d;
   logic                   wr_q, wr_d;
   logic [DATA_SIZE-1:0]   pair_q, pair_d;

   logic                   pick_found;
   logic [IW-1:0]          pick_idx;
   logic                   own_valid;
   logic [DATA_SIZE-1:0]   own_data;

   // last_q doubles as the index of the current owner once a grant is made.
   assign own_valid = req_valid[last_q];
   assign own_data  = req_data[int'(last_q)*DATA_SIZE +: DATA_SIZE];

   always_comb begin : rr_search
      int idx;
      idx        = 0;
      pick_found = 1'b0;
      pick_idx   = last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!pick_found && req_valid[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(idx);
         end
      end
   end

   always_comb begin : next_state
      // NOTE: every _d and output gets a default first, so no branch can infer a latch.
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      beat_d    = beat_q;
      gap_d     = gap_q;
      keys_d    = keys_q;
      wr_d      = 1'b0;
      pair_d    = pair_q;
      req_ready = '0;
      unique case (state_q)
         S_IDLE: begin
            if (keys_q == KW'(MAX_KEYS)) begin
               state_d = S_FULL;
            end else if (pick_found) begin
               grant_d = NUM_REQ'(1) << pick_idx;
               last_d  = pick_idx;
               beat_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            req_ready = grant_q;
            wr_d      = own_valid;
            if (own_valid) begin
               pair_d = own_data;
               beat_d = beat_q + 1'b1;
               if (beat_q == BW'(BURST_LEN - 1)) begin
                  gap_d   = GW'(GAP_CYCLES - 1);
                  keys_d  = keys_q + 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               grant_d = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         S_FULL: begin
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         beat_q  <= '0;
         gap_q   <= '0;
         keys_q  <= '0;
         wr_q    <= 1'b0;
         pair_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         keys_q  <= keys_d;
         wr_q    <= wr_d;
         pair_q  <= pair_d;
      end
   end

   assign grant     = grant_q;
   assign red_write = wr_q;
   assign red_pair  = pair_q;
   assign busy      = (state_q == S_BURST) || (state_q == S_GAP);
   assign full      = (state_q == S_FULL);
   assign keys_sent = keys_q;

endmodule

// File: tb/tb_reduce_scheduler.sv
// Self-checking bench for reduce_scheduler: an integer-level reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized soak.
module tb_reduce_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int BL  = 4;
   localparam int GAP = 2;
   localparam int MK  = 64;
   localparam int KW  = 7;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*DW-1:0]   req_data = '0;
   logic [NR-1:0]      req_ready, grant;
   logic               red_write;
   logic [DW-1:0]      red_pair;
   logic               busy, full;
   logic [KW-1:0]      keys_sent;

   reduce_scheduler #(
      .NUM_REQ(NR), .DATA_SIZE(DW), .BURST_LEN(BL), .GAP_CYCLES(GAP), .MAX_KEYS(MK), .KW(KW)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .grant(grant), .red_write(red_write), .red_pair(red_pair),
      .busy(busy), .full(full), .keys_sent(keys_sent)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Per-requester pending pairs and stall configuration.
   logic [DW-1:0] q [NR][$];
   int stall_pct [NR];
   int stall_at [NR];
   int stall_len [NR];
   int stall_done [NR];
   int acc_cnt [NR];

   // Reference model: who owns the reducer, how far along the word is, keys delivered.
   int            m_owner, m_last, m_beats, m_gap, m_keys, m_cand;
   bit            m_full;
   logic          e_write;
   logic [DW-1:0] e_pair;

   // Per-cycle traces of DUT outputs, index = cycle since reset release.
   logic          tw[$];
   logic [NR-1:0] tg[$];
   logic [NR-1:0] tr[$];
   logic [DW-1:0] tp[$];
   logic [KW-1:0] tk[$];
   logic          tf[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner = -1;
         m_last  = NR - 1;
         m_beats = 0;
         m_gap   = 0;
         m_keys  = 0;
         m_full  = 1'b0;
         e_write = 1'b0;
         e_pair  = '0;
      end else begin
         e_write = 1'b0;
         if (m_full) begin
            m_owner = -1;
         end else if (m_owner < 0) begin
            if (m_keys == MK) begin
               m_full = 1'b1;
            end else begin
               for (int k = 1; k <= NR; k++) begin
                  m_cand = (m_last + k) % NR;
                  if (m_owner < 0 && req_valid[m_cand]) m_owner = m_cand;
               end
               if (m_owner >= 0) begin
                  m_last  = m_owner;
                  m_beats = 0;
               end
            end
         end else if (m_beats < BL) begin
            if (req_valid[m_owner]) begin
               e_write = 1'b1;
               e_pair  = req_data[m_owner*DW +: DW];
               m_beats++;
               if (q[m_owner].size() > 0) void'(q[m_owner].pop_front());
               acc_cnt[m_owner]++;
               if (m_beats == BL) begin
                  m_keys++;
                  m_gap = GAP;
               end
            end
         end else begin
            m_gap--;
            if (m_gap == 0) m_owner = -1;
         end
      end
   end

   task automatic sample();
      logic [NR-1:0] eg, er;
      eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
      er = (m_owner >= 0 && m_beats < BL) ? eg : '0;
      check("grant", grant, eg);
      check("req_ready", req_ready, er);
      check("red_write", red_write, e_write);
      check("red_pair", red_pair, e_pair);
      check("busy", busy, m_owner >= 0);
      check("full", full, m_full);
      check("keys_sent", keys_sent, m_keys);
      tw.push_back(red_write);
      tg.push_back(grant);
      tr.push_back(req_ready);
      tp.push_back(red_pair);
      tk.push_back(keys_sent);
      tf.push_back(full);
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bit v;
         v = (q[i].size() > 0) && ($urandom_range(99) >= stall_pct[i]);
         if (v && acc_cnt[i] == stall_at[i] && stall_done[i] < stall_len[i]) begin
            v = 1'b0;
            stall_done[i]++;
         end
         req_valid[i] = v;
         req_data[i*DW +: DW] = v ? q[i][0] : $urandom();
      end
   endtask

   task automatic clear_cfg();
      for (int i = 0; i < NR; i++) begin
         q[i].delete();
         stall_pct[i]  = 0;
         stall_at[i]   = -1;
         stall_len[i]  = 0;
         stall_done[i] = 0;
         acc_cnt[i]    = 0;
      end
      req_valid = '0;
      req_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_cfg();
      repeat (2) @(negedge clk);
   endtask

   task automatic start();
      rst = 1'b1;
      tw.delete(); tg.delete(); tr.delete(); tp.delete(); tk.delete(); tf.delete();
      sample();
      drive();
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         sample();
         drive();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_g;
      int bad;
      int ones;
      logic [DW-1:0] exp4 [4];

      // Single requester.
      do_reset();
      q[0].push_back(32'h11); q[0].push_back(32'h22); q[0].push_back(32'h33); q[0].push_back(32'h44);
      start();
      step(10);
      check("single_reset_grant", tg[0], 4'b0000);
      check("single_reset_keys", tk[0], 0);
      check("single_grant_c1", tg[1], 4'b0001);
      exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;
      for (int c = 2; c <= 5; c++) begin
         check("single_write", tw[c], 1'b1);
         check("single_pair", tp[c], exp4[c-2]);
      end
      check("single_gap_c6", tw[6], 1'b0);
      check("single_gap_c7", tw[7], 1'b0);
      check("single_keys", tk[9], 1);

      // Round robin with all requesters continuously valid.
      do_reset();
      for (int i = 0; i < NR; i++)
         for (int j = 0; j < 8; j++) q[i].push_back($urandom());
      start();
      step(35);
      check("rr_g1", tg[1], 4'b0001);
      check("rr_g8", tg[8], 4'b0010);
      check("rr_g15", tg[15], 4'b0100);
      check("rr_g22", tg[22], 4'b1000);
      check("rr_g29", tg[29], 4'b0001);
      check("rr_keys35", tk[35], 5);
      ones = 0;
      for (int c = 0; c <= 35; c++) ones += int'(tw[c]);
      check("rr_write_count", ones, 20);

      // Stall: req 2 drops valid for 3 cycles after its 2nd pair; req 0 shows up mid-stall.
      do_reset();
      for (int j = 0; j < 4; j++) q[2].push_back(32'h200 + j);
      for (int j = 0; j < 4; j++) q[0].push_back(32'h100 + j);
      stall_at[2] = 2; stall_len[2] = 3;
      stall_at[0] = 0; stall_len[0] = 4;
      start();
      step(14);
      check("stall_w2", tw[2], 1'b1);
      check("stall_w3", tw[3], 1'b1);
      check("stall_w4", tw[4], 1'b0);
      check("stall_w5", tw[5], 1'b0);
      check("stall_w6", tw[6], 1'b0);
      check("stall_w7", tw[7], 1'b1);
      check("stall_w8", tw[8], 1'b1);
      check("stall_p8", tp[8], 32'h203);
      bad = 0;
      for (int c = 1; c <= 9; c++) if (tg[c] !== 4'b0100) bad++;
      check("stall_grant_held", bad, 0);
      check("stall_next_owner", tg[11], 4'b0001);

      // Full: 64 bursts from req 1, then a 65th request.
      do_reset();
      for (int j = 0; j < 65*BL; j++) q[1].push_back($urandom());
      start();
      step(470);
      check("full_last_grant", tg[442], 4'b0010);
      check("full_keys63", tk[445], 63);
      check("full_keys64", tk[446], 64);
      check("full_flag", tf[449], 1'b1);
      bad = 0;
      for (int c = 449; c <= 470; c++) if (tr[c] !== '0 || tw[c] !== 1'b0 || tk[c] !== 64) bad++;
      check("full_no_65th", bad, 0);

      // Mid-burst reset after a completed word and 2 pairs of the next.
      do_reset();
      for (int j = 0; j < 8; j++) q[0].push_back(32'hC0 + j);
      start();
      step(10);
      check("rst_pre_write", tw[10], 1'b1);
      check("rst_pre_keys", tk[10], 1);
      #2 rst = 1'b0;
      #1;
      check("rst_grant", grant, 0);
      check("rst_ready", req_ready, 0);
      check("rst_write", red_write, 0);
      check("rst_pair", red_pair, 0);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_keys", keys_sent, 0);
      clear_cfg();
      repeat (2) @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         q[0].push_back(32'hD0 + j);
         q[3].push_back(32'hE0 + j);
      end
      start();
      step(10);
      check("rst_prio_req0", tg[1], 4'b0001);

      // Non-owner noise on req 3 during req 0's burst.
      do_reset();
      for (int j = 0; j < 4; j++) begin
         q[0].push_back(32'hA0 + j);
         q[3].push_back(32'hB0 + j);
      end
      stall_pct[3] = 50;
      start();
      step(50);
      for (int c = 2; c <= 5; c++) begin
         check("noise_write", tw[c], 1'b1);
         check("noise_pair", tp[c], 32'hA0 + c - 2);
      end
      first_g = -1;
      for (int c = 8; c <= 50; c++) if (first_g < 0 && tg[c] !== '0) first_g = c;
      check("noise_next_found", first_g >= 0, 1'b1);
      if (first_g >= 0) check("noise_next_req3", tg[first_g], 4'b1000);

      // Randomized soak with random stalls and refills.
      do_reset();
      for (int i = 0; i < NR; i++) begin
         stall_pct[i] = $urandom_range(60);
         for (int j = 0; j < 6; j++) q[i].push_back($urandom());
      end
      start();
      repeat (600) begin
         @(negedge clk);
         sample();
         for (int i = 0; i < NR; i++)
            if (q[i].size() < 2 && $urandom_range(3) == 0) q[i].push_back($urandom());
         drive();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
